// File: rtl/synth_mode_ctrl.sv
// synth_mode_ctrl: PLAY/DEMO/RECORD/REPLAY mode FSM and registered mixer-output mux.
// Define SYNTH_RECORD_EN to build the record/replay buffer; without it only PLAY and DEMO exist.
module synth_mode_ctrl #(
    parameter int NUM_CHANNELS = 8,
    parameter int PITCH_W      = 12,
    parameter int REC_DEPTH    = 64,
    parameter int TICK_DIVIDE  = 749999
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CHANNELS-1:0]         keys,
    input  logic [NUM_CHANNELS*PITCH_W-1:0] key_pitches,
    input  logic                            btn_wave,
    input  logic                            btn_demo,
    input  logic                            btn_rec,
    input  logic [NUM_CHANNELS-1:0]         demo_channel_ena,
    input  logic [NUM_CHANNELS*2-1:0]       demo_waveforms,
    input  logic [NUM_CHANNELS*PITCH_W-1:0] demo_pitches,
    output logic [NUM_CHANNELS-1:0]         channel_ena,
    output logic [NUM_CHANNELS*2-1:0]       waveforms,
    output logic [NUM_CHANNELS*PITCH_W-1:0] pitches,
    output logic                            demo_ena,
    output logic [1:0]                      mode,
    output logic                            rec_full
);

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        DEMO   = 2'd1,
        RECORD = 2'd2,
        REPLAY = 2'd3
    } mode_t;

    mode_t state, next_state;

    logic [NUM_CHANNELS-1:0] keys_q;
    logic                    wave_q, demo_q;
    logic                    wave_rise, demo_rise, key_rise;
    logic [1:0]              wave_sel;

    // Edge detectors load the live inputs on reset so a held button does not fire afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            keys_q <= keys;
            wave_q <= btn_wave;
            demo_q <= btn_demo;
        end else begin
            keys_q <= keys;
            wave_q <= btn_wave;
            demo_q <= btn_demo;
        end
    end

    assign wave_rise = btn_wave & ~wave_q;
    assign demo_rise = btn_demo & ~demo_q;
    assign key_rise  = |(keys & ~keys_q);

    always_ff @(posedge clk) begin
        if (rst)            wave_sel <= 2'd0;
        else if (wave_rise) wave_sel <= wave_sel + 2'd1;
    end

`ifdef SYNTH_RECORD_EN
    localparam int AW = $clog2(REC_DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = NUM_CHANNELS + 2;
    localparam int CW = (TICK_DIVIDE > 0) ? $clog2(TICK_DIVIDE + 1) : 1;

    logic          rec_q, rec_rise;
    logic [CW-1:0] tick_cnt;
    logic          tick, rec_write, last_write;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] length;
    logic [DW-1:0] mem [REC_DEPTH];
    logic [DW-1:0] rd_data;

    always_ff @(posedge clk) begin
        rec_q <= btn_rec;
    end

    assign rec_rise   = btn_rec & ~rec_q;
    assign tick       = (tick_cnt == CW'(TICK_DIVIDE));
    // A button leaving RECORD wins over a write falling on the same cycle.
    assign rec_write  = (state == RECORD) && tick && !demo_rise && !rec_rise;
    assign last_write = rec_write && (wr_ptr == AW'(REC_DEPTH - 1));
`else
    logic unused_rec;
    assign unused_rec = btn_rec;
`endif

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        if (demo_rise) begin
            next_state = (state == DEMO) ? PLAY : DEMO;
`ifdef SYNTH_RECORD_EN
        end else if (rec_rise) begin
            case (state)
                PLAY, DEMO: next_state = RECORD;
                RECORD:     next_state = (wr_ptr == '0) ? PLAY : REPLAY;
                default:    next_state = PLAY;
            endcase
        end else if (key_rise && (state == DEMO || state == REPLAY)) begin
            next_state = PLAY;
        end else if (last_write) begin
            next_state = REPLAY;
`else
        end else if (key_rise && state == DEMO) begin
            next_state = PLAY;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= PLAY;
        else     state <= next_state;
    end

`ifdef SYNTH_RECORD_EN
    always_ff @(posedge clk) begin
        if (rst || next_state != state) tick_cnt <= '0;
        else if (tick)                  tick_cnt <= '0;
        else                            tick_cnt <= tick_cnt + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            length   <= '0;
            rec_full <= 1'b0;
        end else begin
            if (next_state == RECORD && state != RECORD) begin
                wr_ptr   <= '0;
                rec_full <= 1'b0;
            end else if (rec_write) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (last_write) begin
                    rec_full <= 1'b1;
                    length   <= LW'(REC_DEPTH);
                end
            end
            if (state == RECORD && (demo_rise || rec_rise))
                length <= {1'b0, wr_ptr};
            if (next_state == REPLAY && state != REPLAY)
                rd_ptr <= '0;
            else if (state == REPLAY && tick)
                rd_ptr <= ({1'b0, rd_ptr} == length - LW'(1)) ? '0 : rd_ptr + AW'(1);
        end
    end

    // NOTE: the buffer has no reset so it maps onto block RAM; contents are undefined after rst.
    always_ff @(posedge clk) begin
        if (rec_write) mem[wr_ptr] <= {keys, wave_sel};
        rd_data <= mem[rd_ptr];
    end
`else
    assign rec_full = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            channel_ena <= '0;
            waveforms   <= '0;
            pitches     <= '0;
        end else begin
            channel_ena <= keys;
            waveforms   <= {NUM_CHANNELS{wave_sel}};
            pitches     <= key_pitches;
            if (state == DEMO) begin
                channel_ena <= demo_channel_ena;
                waveforms   <= demo_waveforms;
                pitches     <= demo_pitches;
            end
`ifdef SYNTH_RECORD_EN
            else if (state == REPLAY) begin
                channel_ena <= rd_data[DW-1:2];
                waveforms   <= {NUM_CHANNELS{rd_data[1:0]}};
            end
`endif
        end
    end

    assign mode     = state;
    assign demo_ena = (state == DEMO);

endmodule

// File: tb/tb_synth_mode_ctrl.sv
// Directed bench for synth_mode_ctrl (NUM_CHANNELS=4, TICK_DIVIDE=3, REC_DEPTH=4).
// Record/replay scenarios run when SYNTH_RECORD_EN is defined; otherwise btn_rec must be ignored.
module tb_synth_mode_ctrl;

    localparam int NC = 4;
    localparam int PW = 12;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    keys;
    logic [NC*PW-1:0] key_pitches;
    logic             btn_wave, btn_demo, btn_rec;
    logic [NC-1:0]    demo_channel_ena;
    logic [NC*2-1:0]  demo_waveforms;
    logic [NC*PW-1:0] demo_pitches;
    logic [NC-1:0]    channel_ena;
    logic [NC*2-1:0]  waveforms;
    logic [NC*PW-1:0] pitches;
    logic             demo_ena;
    logic [1:0]       mode;
    logic             rec_full;

    int checks   = 0;
    int failures = 0;

    synth_mode_ctrl #(
        .NUM_CHANNELS(NC),
        .PITCH_W     (PW),
        .REC_DEPTH   (4),
        .TICK_DIVIDE (3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .keys            (keys),
        .key_pitches     (key_pitches),
        .btn_wave        (btn_wave),
        .btn_demo        (btn_demo),
        .btn_rec         (btn_rec),
        .demo_channel_ena(demo_channel_ena),
        .demo_waveforms  (demo_waveforms),
        .demo_pitches    (demo_pitches),
        .channel_ena     (channel_ena),
        .waveforms       (waveforms),
        .pitches         (pitches),
        .demo_ena        (demo_ena),
        .mode            (mode),
        .rec_full        (rec_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // which: 0 = wave, 1 = demo, 2 = rec; high for one edge, low for the next.
    task automatic press(input int which);
        case (which)
            0: btn_wave = 1'b1;
            1: btn_demo = 1'b1;
            default: btn_rec = 1'b1;
        endcase
        cyc(1);
        btn_wave = 1'b0;
        btn_demo = 1'b0;
        btn_rec  = 1'b0;
        cyc(1);
    endtask

    initial begin
        rst              = 1'b1;
        keys             = '0;
        key_pitches      = 48'h123456789ABC;
        btn_wave         = 1'b0;
        btn_demo         = 1'b0;
        btn_rec          = 1'b0;
        demo_channel_ena = 4'b1010;
        demo_waveforms   = 8'hE4;
        demo_pitches     = 48'hFEDCBA987654;
        cyc(2);
        check("rst_chan", channel_ena, 0);
        check("rst_wave", waveforms, 0);
        check("rst_pitch", pitches, 0);
        check("rst_mode", mode, 0);
        check("rst_demo_ena", demo_ena, 0);
        check("rst_full", rec_full, 0);

        // Five waveform presses wrap wave_sel to 1.
        rst  = 1'b0;
        keys = 4'b0011;
        cyc(1);
        repeat (5) press(0);
        cyc(1);
        check("play_chan", channel_ena, 4'b0011);
        check("play_wave", waveforms, 8'h55);
        check("play_mode", mode, 0);
        check("play_pitch", pitches, 48'h123456789ABC);

        press(1);
        check("demo_mode", mode, 1);
        check("demo_ena", demo_ena, 1);
        check("demo_chan", channel_ena, 4'b1010);
        check("demo_wave", waveforms, 8'hE4);
        check("demo_pitch", pitches, 48'hFEDCBA987654);
        keys = 4'b0010;
        cyc(1);
        check("demo_keyfall_mode", mode, 1);
        keys = 4'b0011;
        cyc(1);
        check("demo_key_exit_mode", mode, 0);
        check("demo_key_exit_ena", demo_ena, 0);
        cyc(1);
        check("back_play_chan", channel_ena, 4'b0011);

        // Demo outranks record when both rise together.
        btn_demo = 1'b1;
        btn_rec  = 1'b1;
        cyc(1);
        btn_demo = 1'b0;
        btn_rec  = 1'b0;
        check("prio_mode", mode, 1);
        cyc(1);
        press(1);
        check("prio_exit_mode", mode, 0);

`ifdef SYNTH_RECORD_EN
        begin
            logic [3:0] seq [5];
            seq[0] = 4'd1; seq[1] = 4'd2; seq[2] = 4'd4; seq[3] = 4'd8; seq[4] = 4'd1;

            // Fill all four entries: writes land every 4 clocks, last one enters REPLAY.
            press(2);
            check("rec_mode", mode, 2);
            keys = 4'd1; cyc(3);
            keys = 4'd2; cyc(4);
            keys = 4'd4; cyc(4);
            keys = 4'd8; cyc(4);
            check("full_mode", mode, 3);
            check("full_flag", rec_full, 1);
            cyc(2);
            check("replay_wave", waveforms, 8'h55);
            for (int i = 0; i < 5; i++) begin
                check($sformatf("replay_full_%0d", i), channel_ena, seq[i]);
                cyc(4);
            end
            press(2);
            check("replay_exit_mode", mode, 0);

            // Two writes, then stop by button: replay alternates 3,5.
            press(2);
            keys = 4'd3; cyc(3);
            keys = 4'd5; cyc(4);
            btn_rec = 1'b1;
            cyc(1);
            btn_rec = 1'b0;
            check("short_mode", mode, 3);
            check("short_full", rec_full, 0);
            cyc(2);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("replay_short_%0d", i), channel_ena, (i % 2 == 0) ? 4'd3 : 4'd5);
                cyc(4);
            end
            press(2);
            check("short_exit_mode", mode, 0);

            // Zero writes: second record press returns to PLAY.
            press(2);
            check("empty_rec_mode", mode, 2);
            press(2);
            check("empty_exit_mode", mode, 0);

            // Reset while replaying.
            press(1);
            press(2);
            cyc(3);
            press(2);
            check("pre_rst_mode", mode, 3);
            cyc(3);
            check("pre_rst_chan", channel_ena, 4'd5);
            rst = 1'b1;
            cyc(1);
            check("mid_rst_chan", channel_ena, 0);
            check("mid_rst_wave", waveforms, 0);
            check("mid_rst_pitch", pitches, 0);
            check("mid_rst_mode", mode, 0);
            check("mid_rst_demo_ena", demo_ena, 0);
            check("mid_rst_full", rec_full, 0);
            rst = 1'b0;
            cyc(2);
            check("post_rst_mode", mode, 0);
            check("post_rst_chan", channel_ena, 4'd5);
        end
`else
        repeat (3) begin
            press(2);
            check("norec_mode", mode, 0);
        end
        check("norec_full", rec_full, 0);
        check("norec_chan", channel_ena, 4'b0011);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/synth_mode_ctrl.md
SYNTH_MODE_CTRL -- requirements
Module: synth_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8: number of key-driven voice channels.
REQ-002 SHALL have parameter PITCH_W, default 12: width of one channel pitch divider.
REQ-003 SHALL have parameter REC_DEPTH, default 64: record buffer entries (power of two, >=2).
REQ-004 SHALL have parameter TICK_DIVIDE, default 749999: record/replay step every TICK_DIVIDE+1 clk cycles.
REQ-005 SHALL have ports; reset rst, synchronous, active-high; clock clk:
 clk  in  1  system clock
 rst  in  1  synchronous active-high reset
 keys  in  NUM_CHANNELS  debounced key levels, bit i enables channel i
 key_pitches  in  NUM_CHANNELS*PITCH_W  pitch divider per key, channel i at [i*PITCH_W +: PITCH_W]
 btn_wave  in  1  debounced waveform-cycle button
 btn_demo  in  1  debounced demo button
 btn_rec  in  1  debounced record button
 demo_channel_ena  in  NUM_CHANNELS  demo decoder enables
 demo_waveforms  in  NUM_CHANNELS*2  demo decoder waveforms
 demo_pitches  in  NUM_CHANNELS*PITCH_W  demo decoder pitches
 channel_ena  out  NUM_CHANNELS  mixer enables
 waveforms  out  NUM_CHANNELS*2  mixer waveforms
 pitches  out  NUM_CHANNELS*PITCH_W  mixer pitches
 demo_ena  out  1  high only in DEMO
 mode  out  2  PLAY=0, DEMO=1, RECORD=2, REPLAY=3
 rec_full  out  1  buffer filled in last recording

Function
REQ-006 SHALL detect rising edges of btn_wave, btn_demo, btn_rec, keys via one-cycle-delayed copies; only edges act.
REQ-007 SHALL hold 2-bit wave_sel, +1 per btn_wave edge in any mode, wrapping 3->0.
REQ-008 SHALL transition, priority btn_demo > btn_rec > key edge, one event per cycle:
 btn_demo: PLAY->DEMO; DEMO->PLAY; RECORD/REPLAY->DEMO (RECORD first latches length).
 btn_rec: PLAY->RECORD; DEMO->RECORD; RECORD->REPLAY (length>0) or PLAY (length 0); REPLAY->PLAY.
 any key edge: DEMO->PLAY, REPLAY->PLAY; no effect in PLAY/RECORD.
REQ-009 SHALL run tick counter 0..TICK_DIVIDE, cleared on every mode change; tick asserted when counter=TICK_DIVIDE.
REQ-010 On RECORD entry SHALL clear wr_ptr and rec_full; each tick in RECORD writes {keys, wave_sel} to buffer[wr_ptr], wr_ptr+1.
REQ-011 When write REC_DEPTH-1 occurs SHALL set rec_full, length=REC_DEPTH, enter REPLAY same edge.
REQ-012 Leaving RECORD by button SHALL set length=wr_ptr (writes completed so far).
REQ-013 On REPLAY entry SHALL clear rd_ptr; each tick rd_ptr+1, wrapping length-1->0.
REQ-014 Outputs registered, one clk after inputs/state:
 PLAY/RECORD: channel_ena=keys, pitches=key_pitches, waveforms=wave_sel replicated.
 DEMO: demo_* passed through, demo_ena=1.
 REPLAY: channel_ena/waveforms from buffer[rd_ptr] (synchronous read, <=2 clk after rd_ptr change), pitches=key_pitches.
REQ-015 demo_ena SHALL be 1 exactly when mode=DEMO.
REQ-016 Buffer SHALL be inferable single-port-write/single-port-read block RAM, not reset.

Reset
REQ-017 On rst SHALL set mode=PLAY, wave_sel=0, tick counter, wr_ptr, rd_ptr, length=0, rec_full=0, channel_ena=0, waveforms=0, pitches=0, demo_ena=0, edge detectors loaded with current inputs.
REQ-018 rst mid-RECORD/REPLAY SHALL abort, discard length; buffer contents undefined.

Configuration
REQ-019 Macro SYNTH_RECORD_EN defined: RECORD/REPLAY, buffer, rec_full as above.
REQ-020 Undefined: no buffer/pointers, btn_rec ignored, mode only 0/1, rec_full tied 0; PLAY/DEMO unchanged.

Verification (NUM_CHANNELS=4, TICK_DIVIDE=3, REC_DEPTH=4, SYNTH_RECORD_EN unless noted)
REQ-021 keys=4'b0011, btn_wave pulsed 5x -> channel_ena=4'b0011, waveforms=8'h55 (wave_sel=1), mode=0.
REQ-022 btn_demo pulse, demo_channel_ena=4'b1010 -> mode=1, demo_ena=1, channel_ena=4'b1010; key 0 rise -> mode=0, demo_ena=0.
REQ-023 btn_rec, keys 1,2,4,8 on successive ticks -> rec_full=1, mode=3, channel_ena cycles 1,2,4,8,1 every 4 clk.
REQ-024 btn_rec, two ticks (keys 3,5), btn_rec -> mode=3, length=2, channel_ena alternates 3,5; btn_rec at zero ticks -> mode=0.
REQ-025 btn_demo and btn_rec rising same cycle in PLAY -> mode=1; rst asserted in REPLAY -> all outputs 0, mode=0.
REQ-026 SYNTH_RECORD_EN undefined: btn_rec pulses -> mode stays 0, rec_full=0.
